// File: rtl/fifo_uart_pkg.sv
// Shared constants for the FIFO-drain UART transmitter: byte width, line
// levels, FSM state encodings and the even-parity helper.
package fifo_uart_pkg;

    localparam int DATA_W = 8;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_LOAD   = 3'd2;
    localparam logic [2:0] ST_START  = 3'd3;
    localparam logic [2:0] ST_DATA   = 3'd4;
    localparam logic [2:0] ST_PARITY = 3'd5;
    localparam logic [2:0] ST_STOP   = 3'd6;

    // Even parity: the parity bit makes the total number of ones even.
    function automatic logic even_parity(input logic [DATA_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts clk cycles while run is high and pulses bit_tick
// on the last cycle of each serial bit. The count is cleared whenever run
// is low, so every bit period starts cleanly from zero.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic bit_tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] clk_cnt;

    assign bit_tick = run && (clk_cnt == LAST);

    // Cycle counter: wraps on every bit boundary, held at zero when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_cnt <= '0;
        end else if (!run || bit_tick) begin
            clk_cnt <= '0;
        end else begin
            clk_cnt <= clk_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one byte per frame from a FIFO with registered
// (one-cycle latency) read data and sends it as 8N1, LSB first.
// Optional macro FIFO_UART_TX_PARITY_EN inserts an even-parity bit between
// the data bits and the stop bit (11-bit frame instead of 10).
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd_en,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [DATA_W-1:0] shift;
    logic [2:0]        bit_cnt;
    logic              run;
    logic              bit_tick;
`ifdef FIFO_UART_TX_PARITY_EN
    logic              parity;
`endif

    // The bit timer only runs while a serial bit is on the line.
    assign run = (state == ST_START) || (state == ST_DATA) ||
                 (state == ST_PARITY) || (state == ST_STOP);

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .bit_tick (bit_tick)
    );

    // Next-state logic; fifo_empty is only looked at in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) state_nxt = ST_FETCH;
                else             state_nxt = ST_IDLE;
            end
            ST_FETCH: state_nxt = ST_LOAD;
            ST_LOAD:  state_nxt = ST_START;
            ST_START: begin
                if (bit_tick) state_nxt = ST_DATA;
                else          state_nxt = ST_START;
            end
            ST_DATA: begin
                if (bit_tick && (bit_cnt == 3'd7)) begin
`ifdef FIFO_UART_TX_PARITY_EN
                    state_nxt = ST_PARITY;
`else
                    state_nxt = ST_STOP;
`endif
                end else begin
                    state_nxt = ST_DATA;
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_tick) state_nxt = ST_STOP;
                else          state_nxt = ST_PARITY;
            end
`endif
            ST_STOP: begin
                if (bit_tick) state_nxt = ST_IDLE;
                else          state_nxt = ST_STOP;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Shift register and bit counter: load in LOAD (read data now valid),
    // shift out one bit per boundary in DATA. bit_cnt wraps 7->0 into STOP.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift   <= '0;
            bit_cnt <= 3'd0;
        end else if (state == ST_LOAD) begin
            shift   <= fifo_data;
            bit_cnt <= 3'd0;
        end else if ((state == ST_DATA) && bit_tick) begin
            shift   <= {1'b0, shift[DATA_W-1:1]};
            bit_cnt <= bit_cnt + 3'd1;
        end else begin
            shift   <= shift;
            bit_cnt <= bit_cnt;
        end
    end

`ifdef FIFO_UART_TX_PARITY_EN
    // Parity is computed from the byte as it is captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity <= 1'b0;
        end else if (state == ST_LOAD) begin
            parity <= even_parity(fifo_data);
        end else begin
            parity <= parity;
        end
    end
`endif

    // Line level decoded from the state and shift registers.
    always_comb begin
        tx = IDLE_LEVEL;
        case (state)
            ST_START:  tx = START_LEVEL;
            ST_DATA:   tx = shift[0];
`ifdef FIFO_UART_TX_PARITY_EN
            ST_PARITY: tx = parity;
`endif
            ST_STOP:   tx = STOP_LEVEL;
            default:   tx = IDLE_LEVEL;
        endcase
    end

    assign fifo_rd_en = (state == ST_FETCH);
    assign busy       = (state != ST_IDLE);
    assign frame_done = (state == ST_STOP) && bit_tick;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with CLKS_PER_BIT=4 and an 8-entry FIFO
// model whose read data appears one cycle after the read-enable cycle.
module tb_fifo_uart_tx;

    localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int FRAME_CLKS = 44;
`else
    localparam int FRAME_CLKS = 40;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_rd_en, tx, busy, frame_done;

    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       glitch = 1'b0;
    logic [7:0] mem [8];
    logic [2:0] wp, rp;
    logic [3:0] m_cnt;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rd_cnt = 0;
    int fd_cnt = 0;
    int last_rd_cyc = 0;
    int last_fd_cyc = 0;

    always #5 clk = ~clk;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    // FIFO model; glitch forces the empty flag low to probe mid-frame sampling.
    assign fifo_empty = (m_cnt == 4'd0) & ~glitch;

    always @(posedge clk) begin
        if (rst) begin
            wp <= 3'd0; rp <= 3'd0; m_cnt <= 4'd0; fifo_data <= 8'h00;
        end else begin
            if (wr_en) begin
                mem[wp] <= wr_data;
                wp <= wp + 3'd1;
            end
            if (fifo_rd_en && (m_cnt != 4'd0)) begin
                fifo_data <= mem[rp];
                rp <= rp + 3'd1;
            end
            m_cnt <= m_cnt + {3'd0, wr_en} - {3'd0, (fifo_rd_en && (m_cnt != 4'd0))};
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor.
    always @(negedge clk) begin
        if (fifo_rd_en) begin rd_cnt <= rd_cnt + 1; last_rd_cyc <= cyc; end
        if (frame_done) begin fd_cnt <= fd_cnt + 1; last_fd_cyc <= cyc; end
    end

    function automatic logic [47:0] exp_wave(input logic [7:0] d);
        logic [47:0] w;
        w = '1;
        for (int k = 0; k < CPB; k++) w[k] = 1'b0;
        for (int b = 0; b < 8; b++)
            for (int k = 0; k < CPB; k++) w[CPB + CPB*b + k] = d[b];
`ifdef FIFO_UART_TX_PARITY_EN
        for (int k = 0; k < CPB; k++) w[9*CPB + k] = ^d;
`endif
        return w;
    endfunction

    // Called at a negedge; the write is sampled at the following posedge.
    task automatic push(input logic [7:0] d);
        wr_en = 1'b1; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Record one frame starting at the first tx low sample.
    task automatic capture_frame(output logic [47:0] w, output logic [47:0] fd,
                                 output bit bz, output int st, output bit got);
        w = '1; fd = '0; bz = 1'b1; st = 0; got = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (tx === 1'b0) begin got = 1'b1; break; end
        end
        if (got) begin
            st = cyc;
            w[0] = tx; fd[0] = frame_done; bz = bz & busy;
            for (int i = 1; i < FRAME_CLKS; i++) begin
                @(negedge clk);
                w[i] = tx; fd[i] = frame_done; bz = bz & (busy === 1'b1);
            end
        end
    endtask

    task automatic test_reset;
        int bad_tx, bad_busy, rd0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", tx); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%b exp=0", fifo_rd_en); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
        rd0 = rd_cnt; bad_tx = 0; bad_busy = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1) bad_tx++;
            if (busy !== 1'b0) bad_busy++;
        end
        checks++; if (rd_cnt != rd0) begin failures++; $display("FAIL empty_rd_en got=%0d exp=0", rd_cnt - rd0); end
        checks++; if (bad_tx != 0) begin failures++; $display("FAIL empty_tx_idle bad=%0d exp=0", bad_tx); end
        checks++; if (bad_busy != 0) begin failures++; $display("FAIL empty_busy bad=%0d exp=0", bad_busy); end
    endtask

    task automatic test_single;
        logic [47:0] w, fd, efd;
        bit bz, got;
        int st, rd0, fd0;
        efd = '0; efd[FRAME_CLKS-1] = 1'b1;
        rd0 = rd_cnt; fd0 = fd_cnt;
        push(8'hA5);
        capture_frame(w, fd, bz, st, got);
        checks++; if (!got) begin failures++; $display("FAIL single_start got=timeout exp=start"); end
        checks++; if (w !== exp_wave(8'hA5)) begin failures++; $display("FAIL single_wave got=%h exp=%h", w, exp_wave(8'hA5)); end
        checks++; if (fd !== efd) begin failures++; $display("FAIL single_frame_done got=%h exp=%h", fd, efd); end
        checks++; if (!bz) begin failures++; $display("FAIL single_busy got=0 exp=1"); end
        checks++; if (st - last_rd_cyc != 2) begin failures++; $display("FAIL single_rd_to_start got=%0d exp=2", st - last_rd_cyc); end
        repeat (6) @(negedge clk);
        checks++; if (rd_cnt - rd0 != 1) begin failures++; $display("FAIL single_rd_count got=%0d exp=1", rd_cnt - rd0); end
        checks++; if (fd_cnt - fd0 != 1) begin failures++; $display("FAIL single_fd_count got=%0d exp=1", fd_cnt - fd0); end
        checks++; if (tx !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL single_idle got=tx%b/busy%b exp=tx1/busy0", tx, busy); end
    endtask

    task automatic test_back_to_back;
        logic [7:0]  bytes [3];
        logic [47:0] w, fd;
        bit bz, got;
        int st [3];
        int rd0;
        bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h3C;
        rd0 = rd_cnt;
        for (int i = 0; i < 3; i++) push(bytes[i]);
        for (int i = 0; i < 3; i++) begin
            capture_frame(w, fd, bz, st[i], got);
            checks++; if (!got || w !== exp_wave(bytes[i])) begin
                failures++; $display("FAIL b2b_wave%0d got=%h exp=%h", i, w, exp_wave(bytes[i]));
            end
        end
        checks++; if (st[1] - st[0] != FRAME_CLKS + 3) begin failures++; $display("FAIL b2b_gap01 got=%0d exp=%0d", st[1] - st[0], FRAME_CLKS + 3); end
        checks++; if (st[2] - st[1] != FRAME_CLKS + 3) begin failures++; $display("FAIL b2b_gap12 got=%0d exp=%0d", st[2] - st[1], FRAME_CLKS + 3); end
        repeat (6) @(negedge clk);
        checks++; if (rd_cnt - rd0 != 3) begin failures++; $display("FAIL b2b_rd_count got=%0d exp=3", rd_cnt - rd0); end
    endtask

    task automatic test_reset_mid_frame;
        logic [47:0] w, fd, efd;
        bit bz, got;
        int st, fd0;
        efd = '0; efd[FRAME_CLKS-1] = 1'b1;
        push(8'h55);
        got = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (tx === 1'b0) begin got = 1'b1; break; end
        end
        checks++; if (!got) begin failures++; $display("FAIL midrst_start got=timeout exp=start"); end
        repeat (CPB + 3*CPB + 1) @(negedge clk);
        checks++; if (tx !== 1'b0) begin failures++; $display("FAIL midrst_bit3 got=%b exp=0", tx); end
        fd0 = fd_cnt;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (tx !== 1'b1) begin failures++; $display("FAIL midrst_tx got=%b exp=1", tx); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_idle got=busy%b exp=busy0", busy); end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (fd_cnt != fd0) begin failures++; $display("FAIL midrst_no_frame_done got=%0d exp=0", fd_cnt - fd0); end
        push(8'h81);
        capture_frame(w, fd, bz, st, got);
        checks++; if (!got || w !== exp_wave(8'h81)) begin failures++; $display("FAIL midrst_next_wave got=%h exp=%h", w, exp_wave(8'h81)); end
        checks++; if (fd !== efd) begin failures++; $display("FAIL midrst_next_fd got=%h exp=%h", fd, efd); end
    endtask

    task automatic test_empty_toggle;
        logic [47:0] w, fd;
        bit bz, got;
        int st, rd0;
        rd0 = rd_cnt;
        push(8'h5A);
        fork
            capture_frame(w, fd, bz, st, got);
            begin
                repeat (12) @(negedge clk);
                glitch = 1'b1;
                repeat (3) @(negedge clk);
                glitch = 1'b0;
                @(negedge clk);
                glitch = 1'b1;
                @(negedge clk);
                glitch = 1'b0;
                push(8'hC3);
            end
        join
        checks++; if (!got || w !== exp_wave(8'h5A)) begin failures++; $display("FAIL toggle_wave0 got=%h exp=%h", w, exp_wave(8'h5A)); end
        checks++; if (rd_cnt - rd0 != 1) begin failures++; $display("FAIL toggle_no_extra_rd got=%0d exp=1", rd_cnt - rd0); end
        capture_frame(w, fd, bz, st, got);
        checks++; if (!got || w !== exp_wave(8'hC3)) begin failures++; $display("FAIL toggle_wave1 got=%h exp=%h", w, exp_wave(8'hC3)); end
        checks++; if (last_rd_cyc - last_fd_cyc != 2) begin failures++; $display("FAIL toggle_pop_timing got=%0d exp=2", last_rd_cyc - last_fd_cyc); end
        repeat (6) @(negedge clk);
        checks++; if (rd_cnt - rd0 != 2) begin failures++; $display("FAIL toggle_rd_count got=%0d exp=2", rd_cnt - rd0); end
    endtask

`ifdef FIFO_UART_TX_PARITY_EN
    task automatic test_parity;
        logic [47:0] w, fd, efd;
        bit bz, got;
        int st;
        efd = '0; efd[43] = 1'b1;
        push(8'h07);
        capture_frame(w, fd, bz, st, got);
        checks++; if (w[36] !== 1'b1) begin failures++; $display("FAIL parity_07 got=%b exp=1", w[36]); end
        checks++; if (!got || w !== exp_wave(8'h07)) begin failures++; $display("FAIL parity_07_wave got=%h exp=%h", w, exp_wave(8'h07)); end
        checks++; if (fd !== efd) begin failures++; $display("FAIL parity_len got=%h exp=%h", fd, efd); end
        push(8'h03);
        capture_frame(w, fd, bz, st, got);
        checks++; if (w[36] !== 1'b0) begin failures++; $display("FAIL parity_03 got=%b exp=0", w[36]); end
        checks++; if (!got || w !== exp_wave(8'h03)) begin failures++; $display("FAIL parity_03_wave got=%h exp=%h", w, exp_wave(8'h03)); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_reset_mid_frame();
        test_empty_toggle();
`ifdef FIFO_UART_TX_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
